// File: rtl/mem_arbiter2_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter2_if
//  Description : picorv32-style native memory port (valid/ready, addr,
//                wdata, wstrb, rdata). The requester uses the master modport
//                and the responder uses the slave modport.
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_arbiter2_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                valid;
   logic                ready;
   logic [ADDR_W-1:0]   addr;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic [DATA_W-1:0]   rdata;

   // Requester side: issues the command, receives completion and read data.
   modport master (output valid, addr, wdata, wstrb, input ready, rdata);
   // Responder side: accepts the command, returns completion and read data.
   modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface
`default_nettype wire

// File: rtl/mem_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter2
//  Description : Two-master, single-slave round-robin arbiter for the
//                picorv32 native memory interface. One outstanding
//                transaction; the command fields are latched at grant.
//                Optional macro MEM_ARB_TIMEOUT_EN adds a response timeout
//                that completes a stalled transaction with 32'hDEADBEEF
//                and raises a sticky timeout_err.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter2 #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 1024
) (
   input  wire logic      clock,
   input  wire logic      reset,
   mem_arbiter2_if.slave  m0,
   mem_arbiter2_if.slave  m1,
   mem_arbiter2_if.master mem,
   output logic           busy,
   output logic           owner,
   output logic           timeout_err
);

   localparam int STRB_W = DATA_W / 8;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic                busy_q, busy_d;
   logic                owner_q, owner_d;
   logic                mem_valid_q, mem_valid_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;

   logic                w_req_any;
   logic                w_winner;
   logic                w_expire;
   logic                w_done;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam int FILL_REP = (DATA_W + 31) / 32;
   localparam logic [FILL_REP*32-1:0] C_FILL_WIDE = {FILL_REP{32'hDEADBEEF}};
   localparam logic [DATA_W-1:0] C_FILL = C_FILL_WIDE[DATA_W-1:0];

   logic [CNT_W-1:0]    count_q, count_d;
   logic                terr_q, terr_d;

   // Expiry only when the slave is still silent; a same-cycle mem_ready wins.
   assign w_expire = (state_q == ST_BUSY) && !mem.ready && (count_q == C_CNT_LAST);
`else
   assign w_expire = 1'b0;
`endif

   // Round-robin: on a tie the master that did not own the port last wins.
   assign w_req_any = m0.valid | m1.valid;
   assign w_winner  = (m0.valid & m1.valid) ? ~owner_q : m1.valid;

   // Completion is decided purely by the slave (or expiry); a master that
   // drops valid mid-transaction still receives its ready pulse.
   assign w_done    = (state_q == ST_BUSY) && (mem.ready || w_expire);

   assign m0.ready  = w_done && !owner_q;
   assign m1.ready  = w_done &&  owner_q;

`ifdef MEM_ARB_TIMEOUT_EN
   assign m0.rdata  = (w_expire && !owner_q) ? C_FILL : mem.rdata;
   assign m1.rdata  = (w_expire &&  owner_q) ? C_FILL : mem.rdata;
   assign timeout_err = terr_q;
`else
   assign m0.rdata  = mem.rdata;
   assign m1.rdata  = mem.rdata;
   assign timeout_err = 1'b0;
`endif

   assign mem.valid = mem_valid_q;
   assign mem.addr  = mem_addr_q;
   assign mem.wdata = mem_wdata_q;
   assign mem.wstrb = mem_wstrb_q;
   assign busy      = busy_q;
   assign owner     = owner_q;

   // Next-state logic: grant and latch in IDLE, wait for completion in BUSY.
   always_comb begin
      state_d     = state_q;
      busy_d      = busy_q;
      owner_d     = owner_q;
      mem_valid_d = mem_valid_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wstrb_d = mem_wstrb_q;
`ifdef MEM_ARB_TIMEOUT_EN
      count_d     = count_q;
      terr_d      = terr_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (w_req_any) begin
               state_d     = ST_BUSY;
               busy_d      = 1'b1;
               mem_valid_d = 1'b1;
               owner_d     = w_winner;
               mem_addr_d  = w_winner ? m1.addr  : m0.addr;
               mem_wdata_d = w_winner ? m1.wdata : m0.wdata;
               mem_wstrb_d = w_winner ? m1.wstrb : m0.wstrb;
`ifdef MEM_ARB_TIMEOUT_EN
               count_d     = '0;
`endif
            end
         end
         ST_BUSY: begin
            // Returning to IDLE forces one idle cycle, so a slave that keeps
            // ready high cannot complete a second transaction by accident.
            if (w_done) begin
               state_d     = ST_IDLE;
               busy_d      = 1'b0;
               mem_valid_d = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
               if (w_expire) begin
                  terr_d = 1'b1;
               end
`endif
            end
`ifdef MEM_ARB_TIMEOUT_EN
            else begin
               count_d = count_q + CNT_W'(1);
            end
`endif
         end
         default: begin
            state_d     = ST_IDLE;
            busy_d      = 1'b0;
            mem_valid_d = 1'b0;
         end
      endcase
   end

   // State and registered outputs; owner resets to 1 so master 0 wins the first tie.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         busy_q      <= 1'b0;
         owner_q     <= 1'b1;
         mem_valid_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_wstrb_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
         count_q     <= '0;
         terr_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         owner_q     <= owner_d;
         mem_valid_q <= mem_valid_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
`ifdef MEM_ARB_TIMEOUT_EN
         count_q     <= count_d;
         terr_q      <= terr_d;
`endif
      end
   end

endmodule
`default_nettype wire
